// File: rtl/core_pkg.sv
// Shared constants and ALU operation encoding for the core.
package core_pkg;

   localparam int DATA_W      = 32;
   localparam int INST_W      = 32;
   localparam int INST_ADDR_W = 8;
   localparam int NREGS       = 32;

   localparam logic [6:0] OPCODE_ALUI = 7'b0010011;
   localparam logic [6:0] OPCODE_ALUR = 7'b0110011;

   localparam logic [2:0] func3_ADD_SUB = 3'b000;
   localparam logic [2:0] func3_SLL     = 3'b001;
   localparam logic [2:0] func3_SLT     = 3'b010;
   localparam logic [2:0] func3_SLTU    = 3'b011;
   localparam logic [2:0] func3_XOR     = 3'b100;
   localparam logic [2:0] func3_SRL_SRA = 3'b101;
   localparam logic [2:0] func3_OR      = 3'b110;
   localparam logic [2:0] func3_AND     = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

endpackage

// File: rtl/core_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// x0 always reads as zero and is never written.
module core_regfile
   import core_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [4:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [4:0]        raddr1_i,
   input  logic [4:0]        raddr2_i,
   output logic [DATA_W-1:0] rdata1_o,
   output logic [DATA_W-1:0] rdata2_o
);

   logic [DATA_W-1:0] REGS [0:NREGS-1];

   always_ff @(posedge clk) begin
      if (we_i && (waddr_i != 5'd0)) begin
         REGS[waddr_i] <= wdata_i;
      end
   end

   assign rdata1_o = (raddr1_i == 5'd0) ? '0 : REGS[raddr1_i];
   assign rdata2_o = (raddr2_i == 5'd0) ? '0 : REGS[raddr2_i];

endmodule

// File: rtl/core.sv
// Single-cycle RV32I OP/OP-IMM core fetching from a combinational program memory.
// Define CORE_INSTRET_EN to add the retired-instruction counter port instret.
module core
   import core_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [INST_W-1:0]      progmem_data,
`ifdef CORE_INSTRET_EN
   output logic [31:0]            instret,
`endif
   output logic [INST_ADDR_W-1:0] progmem_addr
);

   logic [INST_ADDR_W-1:0] pc_q, pc_d;
   logic [6:0]             opcode;
   logic [2:0]             func3;
   logic [4:0]             rd, rs1, rs2;
   logic [DATA_W-1:0]      imm, rs1_data, rs2_data, op_b, alu_res;
   logic [4:0]             shamt;
   logic                   dec_we, use_imm, rf_we;
   alu_op_e                alu_op;

   assign opcode = progmem_data[6:0];
   assign rd     = progmem_data[11:7];
   assign func3  = progmem_data[14:12];
   assign rs1    = progmem_data[19:15];
   assign rs2    = progmem_data[24:20];
   assign imm    = {{(DATA_W-12){progmem_data[31]}}, progmem_data[31:20]};

   always_comb begin
      dec_we  = 1'b0;
      use_imm = 1'b0;
      alu_op  = ALU_ADD;
      if (opcode == OPCODE_ALUI || opcode == OPCODE_ALUR) begin
         dec_we  = 1'b1;
         use_imm = (opcode == OPCODE_ALUI);
         case (func3)
            func3_ADD_SUB: alu_op = (!use_imm && progmem_data[30]) ? ALU_SUB : ALU_ADD;
            func3_SLL:     alu_op = ALU_SLL;
            func3_SLT:     alu_op = ALU_SLT;
            func3_SLTU:    alu_op = ALU_SLTU;
            func3_XOR:     alu_op = ALU_XOR;
            func3_SRL_SRA: alu_op = progmem_data[30] ? ALU_SRA : ALU_SRL;
            func3_OR:      alu_op = ALU_OR;
            default:       alu_op = ALU_AND;
         endcase
      end
   end

   // For OP-IMM the low immediate bits are exactly inst[24:20], the shamt field.
   assign op_b  = use_imm ? imm : rs2_data;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_res = '0;
      case (alu_op)
         ALU_ADD:  alu_res = rs1_data + op_b;
         ALU_SUB:  alu_res = rs1_data - op_b;
         ALU_SLL:  alu_res = rs1_data << shamt;
         ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(rs1_data) < $signed(op_b)};
         ALU_SLTU: alu_res = {{(DATA_W-1){1'b0}}, rs1_data < op_b};
         ALU_XOR:  alu_res = rs1_data ^ op_b;
         ALU_SRL:  alu_res = rs1_data >> shamt;
         ALU_SRA:  alu_res = $unsigned($signed(rs1_data) >>> shamt);
         ALU_OR:   alu_res = rs1_data | op_b;
         ALU_AND:  alu_res = rs1_data & op_b;
         default:  alu_res = '0;
      endcase
   end

   assign rf_we = en && !rst && dec_we;

   core_regfile regfile (
      .clk      (clk),
      .we_i     (rf_we),
      .waddr_i  (rd),
      .wdata_i  (alu_res),
      .raddr1_i (rs1),
      .raddr2_i (rs2),
      .rdata1_o (rs1_data),
      .rdata2_o (rs2_data)
   );

   assign pc_d = pc_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
      end else if (en) begin
         pc_q <= pc_d;
      end
   end

   assign progmem_addr = pc_q;

`ifdef CORE_INSTRET_EN
   logic [31:0] instret_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         instret_q <= '0;
      end else if (en) begin
         instret_q <= instret_q + 32'd1;
      end
   end

   assign instret = instret_q;
`endif

endmodule

// File: tb/tb_core.sv
// Directed bench for core: preloads registers, runs a fixed program and checks
// register contents and the PC after each step against hand-computed values.
module tb_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] progmem_data;
   logic [7:0]  progmem_addr;
`ifdef CORE_INSTRET_EN
   logic [31:0] instret;
`endif

   logic [31:0] imem [0:255];
   int          checks   = 0;
   int          failures = 0;
   int          exp_ret  = 0;

   always #5 clk = ~clk;

   assign progmem_data = imem[progmem_addr];

   core dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .progmem_data (progmem_data),
`ifdef CORE_INSTRET_EN
      .instret      (instret),
`endif
      .progmem_addr (progmem_addr)
   );

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (en && !rst) exp_ret++;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
      imem[0]  = enc_i(12'd2,   5'd0, 3'b000, 5'd0);             // ADDI x0,x0,2
      imem[1]  = enc_i(12'hFF6, 5'd0, 3'b000, 5'd3);             // ADDI x3,x0,-10
      imem[2]  = enc_i(12'd11,  5'd1, 3'b000, 5'd4);             // ADDI x4,x1,11
      imem[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd4);         // ADD  x4,x1,x2
      imem[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd5);         // AND  x5,x1,x2
      imem[5]  = enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd6);         // SUB  x6,x3,x1
      imem[6]  = enc_i(12'h402, 5'd3, 3'b101, 5'd7);             // SRAI x7,x3,2
      imem[7]  = enc_i(12'h002, 5'd3, 3'b101, 5'd8);             // SRLI x8,x3,2
      imem[8]  = enc_r(7'h00, 5'd1, 5'd3, 3'b010, 5'd9);         // SLT  x9,x3,x1
      imem[9]  = enc_r(7'h00, 5'd1, 5'd3, 3'b011, 5'd10);        // SLTU x10,x3,x1
      imem[10] = enc_i(12'h100, 5'd0, 3'b000, 5'd1);             // ADDI x1,x0,0x100
      imem[11] = enc_i(12'hFFF, 5'd1, 3'b000, 5'd1);             // ADDI x1,x1,-1
      imem[12] = enc_i(12'd2,   5'd1, 3'b000, 5'd1);
      imem[13] = enc_i(12'd4,   5'd1, 3'b000, 5'd1);
      imem[14] = enc_i(12'd8,   5'd1, 3'b000, 5'd1);
      imem[15] = enc_i(12'h0F0, 5'd1, 3'b100, 5'd11);            // XORI x11,x1,0xF0
      imem[16] = enc_i(12'hF00, 5'd2, 3'b110, 5'd12);            // ORI  x12,x2,-256
      imem[17] = enc_i(12'h0FF, 5'd1, 3'b111, 5'd13);            // ANDI x13,x1,0xFF
      imem[18] = enc_i(12'h004, 5'd2, 3'b001, 5'd14);            // SLLI x14,x2,4
      imem[19] = enc_i(12'hFF7, 5'd3, 3'b010, 5'd15);            // SLTI x15,x3,-9
      imem[20] = enc_i(12'd5,   5'd3, 3'b011, 5'd16);            // SLTIU x16,x3,5
      imem[21] = enc_r(7'h00, 5'd5, 5'd3, 3'b101, 5'd17);        // SRL  x17,x3,x5
      imem[22] = enc_r(7'h20, 5'd5, 5'd3, 3'b101, 5'd18);        // SRA  x18,x3,x5
      imem[23] = enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd19);        // XOR  x19,x1,x2
      imem[24] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd20);        // OR   x20,x1,x2
      imem[25] = enc_r(7'h00, 5'd1, 5'd2, 3'b001, 5'd21);        // SLL  x21,x2,x1 (shamt 13)
      imem[26] = {20'hABCDE, 5'd22, 7'b0110111};                 // LUI: not executed
      imem[27] = enc_i(12'd1, 5'd0, 3'b000, 5'd23);              // ADDI x23,x0,1
      imem[28] = enc_i(12'd7, 5'd0, 3'b000, 5'd24);              // ADDI x24,x0,7

      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      step();
      rst = 1'b0;
      check("reset_pc", {24'd0, progmem_addr}, 32'd0);
`ifdef CORE_INSTRET_EN
      check("reset_instret", instret, 32'd0);
`endif
      dut.regfile.REGS[0]  <= 32'd0;
      dut.regfile.REGS[1]  <= 32'd12;
      dut.regfile.REGS[2]  <= 32'd100;
      dut.regfile.REGS[22] <= 32'h0000_DEAD;
      dut.regfile.REGS[23] <= 32'h0000_0055;
      dut.regfile.REGS[24] <= 32'h0000_0077;
      step();
      check("en0_pc_hold", {24'd0, progmem_addr}, 32'd0);

      en = 1'b1;
      step(); check("x0_write_ignored", dut.regfile.REGS[0], 32'd0);
              check("pc_advance",       {24'd0, progmem_addr}, 32'd1);
      step(); check("addi_neg",  dut.regfile.REGS[3], 32'hFFFF_FFF6);
      step(); check("addi_pos",  dut.regfile.REGS[4], 32'd23);
      step(); check("add",       dut.regfile.REGS[4], 32'd112);
      step(); check("and",       dut.regfile.REGS[5], 32'd4);
      step(); check("sub",       dut.regfile.REGS[6], 32'hFFFF_FFEA);
      step(); check("srai",      dut.regfile.REGS[7], 32'hFFFF_FFFD);
      step(); check("srli",      dut.regfile.REGS[8], 32'h3FFF_FFFD);
      step(); check("slt",       dut.regfile.REGS[9], 32'd1);
      step(); check("sltu",      dut.regfile.REGS[10], 32'd0);
      step(); check("chain0",    dut.regfile.REGS[1], 32'd256);
      step(); check("chain1",    dut.regfile.REGS[1], 32'd255);
      step(); check("chain2",    dut.regfile.REGS[1], 32'd257);
      step(); check("chain3",    dut.regfile.REGS[1], 32'd261);
      step(); check("chain4",    dut.regfile.REGS[1], 32'd269);
      step(); check("xori",      dut.regfile.REGS[11], 32'h0000_01FD);
      step(); check("ori",       dut.regfile.REGS[12], 32'hFFFF_FF64);
      step(); check("andi",      dut.regfile.REGS[13], 32'h0000_000D);
      step(); check("slli",      dut.regfile.REGS[14], 32'h0000_0640);
      step(); check("slti",      dut.regfile.REGS[15], 32'd1);
      step(); check("sltiu",     dut.regfile.REGS[16], 32'd0);
      step(); check("srl",       dut.regfile.REGS[17], 32'h0FFF_FFFF);
      step(); check("sra",       dut.regfile.REGS[18], 32'hFFFF_FFFF);
      step(); check("xor",       dut.regfile.REGS[19], 32'h0000_0169);
      step(); check("or",        dut.regfile.REGS[20], 32'h0000_016D);
      step(); check("sll_mask",  dut.regfile.REGS[21], 32'h000C_8000);
      step(); check("bad_opcode_nop", dut.regfile.REGS[22], 32'h0000_DEAD);
              check("bad_opcode_pc",  {24'd0, progmem_addr}, 32'd27);

      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("freeze_pc",  {24'd0, progmem_addr}, 32'd27);
         check("freeze_reg", dut.regfile.REGS[23], 32'h0000_0055);
      end
      en = 1'b1;
      step(); check("resume_reg", dut.regfile.REGS[23], 32'd1);
              check("resume_pc",  {24'd0, progmem_addr}, 32'd28);
`ifdef CORE_INSTRET_EN
      check("instret_count", instret, exp_ret);
`endif

      rst = 1'b1;
      step(); check("midrst_pc",  {24'd0, progmem_addr}, 32'd0);
              check("midrst_reg", dut.regfile.REGS[24], 32'h0000_0077);
              check("midrst_keep", dut.regfile.REGS[1], 32'd269);
`ifdef CORE_INSTRET_EN
      check("midrst_instret", instret, 32'd0);
`endif
      rst = 1'b0;
      en  = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
